// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I front end.
// fetch_entry_t is the payload carried by both fetch FIFOs.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Small in-order FIFO of fetch entries with flush and occupancy count.
// The head entry is visible combinationally so the consumer sees it the cycle it lands.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  pop_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: PC, credit-limited imem requests, wrong-path discard
// after redirects, and an instruction queue feeding the decoder.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              BUF_DEPTH       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            misaligned_err
);

    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] pc_reg;
    logic            active_reg;
    logic            misaligned_err_reg;
    logic [OCW-1:0]  discard_reg;
    logic [OCW-1:0]  outstanding;
    logic [QCW-1:0]  q_count;
    fetch_entry_t    pcq_push;
    fetch_entry_t    pcq_head;
    fetch_entry_t    iq_push;
    fetch_entry_t    iq_head;
    logic            req_fire;
    logic            rsp_keep;
    logic            pop_fire;
    logic            unused_pcq_instr;

    // Outstanding counts every request still owed a response, including ones
    // already marked for discard, so credits return only as discards drain.
    assign imem_req_valid = active_reg && !misaligned_err_reg && !redirect_valid
                         && (int'(outstanding) < MAX_OUTSTANDING)
                         && (int'(outstanding) + int'(q_count) < BUF_DEPTH);
    assign imem_req_addr  = pc_reg;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_keep = imem_rsp_valid && (discard_reg == '0) && !redirect_valid;
    assign pop_fire = instr_valid && instr_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg             <= RESET_PC;
            active_reg         <= 1'b0;
            misaligned_err_reg <= 1'b0;
            discard_reg        <= '0;
        end else begin
            active_reg <= 1'b1;
            if (redirect_valid) begin
                if (is_aligned(redirect_pc)) begin
                    pc_reg             <= redirect_pc;
                    misaligned_err_reg <= 1'b0;
                end else begin
                    misaligned_err_reg <= 1'b1;
                end
                // A response landing in the redirect cycle is dropped here rather than counted.
                discard_reg <= outstanding - OCW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + 32'd4;
                end
                if (imem_rsp_valid && (discard_reg != '0)) begin
                    discard_reg <= discard_reg - OCW'(1);
                end
            end
        end
    end

    // Request-PC FIFO: its occupancy is the outstanding-request count.
    assign pcq_push = '{instr: '0, pc: pc_reg};

    fetch_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (req_fire),
        .push_data(pcq_push),
        .pop      (imem_rsp_valid),
        .pop_data (pcq_head),
        .count    (outstanding)
    );

    assign unused_pcq_instr = ^pcq_head.instr;

    assign iq_push = '{instr: imem_rsp_data, pc: pcq_head.pc};

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_instr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (rsp_keep),
        .push_data(iq_push),
        .pop      (pop_fire),
        .pop_data (iq_head),
        .count    (q_count)
    );

    assign instr_valid    = (q_count != '0);
    assign instr          = instr_valid ? iq_head.instr : NOP_INSTR;
    assign instr_pc       = instr_valid ? iq_head.pc : '0;
    assign misaligned_err = misaligned_err_reg;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: transaction-level model of program-order delivery,
// a variable-latency in-order memory, and directed scenarios with literal checks.
module tb_rv32i_fetch;

    localparam int MAXO = 2;
    localparam int BUFD = 2;

    typedef struct {
        logic [31:0] pc;
        int          epoch;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (reset PC 0)
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        misaligned_err;

    // Wrap-around DUT (reset PC near the top of the address space)
    logic        rst1_n;
    logic        imem_req_valid1, imem_req_ready1;
    logic [31:0] imem_req_addr1;
    logic        imem_rsp_valid1;
    logic [31:0] imem_rsp_data1;
    logic        redirect_valid1;
    logic [31:0] redirect_pc1;
    logic        instr_valid1, instr_ready1;
    logic [31:0] instr1, instr_pc1;
    logic        misaligned_err1;

    rv32i_fetch #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(MAXO), .BUF_DEPTH(BUFD)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .misaligned_err(misaligned_err)
    );

    rv32i_fetch #(.RESET_PC(32'hFFFF_FFF8), .MAX_OUTSTANDING(MAXO), .BUF_DEPTH(BUFD)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .imem_req_valid(imem_req_valid1), .imem_req_ready(imem_req_ready1), .imem_req_addr(imem_req_addr1),
        .imem_rsp_valid(imem_rsp_valid1), .imem_rsp_data(imem_rsp_data1),
        .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
        .instr_valid(instr_valid1), .instr_ready(instr_ready1), .instr(instr1), .instr_pc(instr_pc1),
        .misaligned_err(misaligned_err1)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    req_t        memq[$];
    logic [31:0] mq[$];
    logic [31:0] seen[$];
    logic [31:0] seen1[$];
    req_t        rsp_item;
    logic [31:0] exp_req_pc;
    logic        err_m;
    int          epoch, cyc, last_due, lat, due_v;
    int          fire_count, first_fire, first_valid;
    logic        prev_stall;
    logic        pend1;
    logic [31:0] pend1_addr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_run(input string name, input int start, input logic [31:0] base, input int min_len);
        chk({name, "_len"}, 32'(seen.size() - start >= min_len), 32'd1);
        for (int k = 0; start + k < seen.size(); k++) begin
            chk(name, seen[start + k], base + 32'(4 * k));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare process and model update for the main DUT.
    always @(negedge clk) begin
        if (!rst_n) begin
            memq.delete();
            mq.delete();
            exp_req_pc = 32'h0;
            err_m      = 1'b0;
            epoch      = 0;
            cyc        = 0;
            last_due   = -1;
            prev_stall = 1'b0;
        end else begin
            chk("misaligned_err", 32'(misaligned_err), 32'(err_m));
            if (redirect_valid || err_m) chk("req_blocked", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
            if (prev_stall && !redirect_valid) chk("req_hold", 32'(imem_req_valid), 32'd1);
            chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
            if (instr_valid && mq.size() != 0) begin
                chk("instr_pc", instr_pc, mq[0]);
                chk("instr", instr, word(mq[0]));
            end
            chk("credit_bound", 32'(memq.size() <= MAXO && memq.size() + mq.size() <= BUFD), 32'd1);

            if (imem_rsp_valid && memq.size() != 0) begin
                rsp_item = memq.pop_front();
                if (rsp_item.epoch == epoch && !redirect_valid) mq.push_back(rsp_item.pc);
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                if (mq.size() != 0) void'(mq.pop_front());
                seen.push_back(instr_pc);
            end
            if (instr_valid && first_valid < 0) first_valid = cyc;
            if (imem_req_valid && imem_req_ready) begin
                due_v = cyc + lat;
                if (due_v <= last_due) due_v = last_due + 1;
                memq.push_back('{pc: exp_req_pc, epoch: epoch, due: due_v});
                last_due   = due_v;
                exp_req_pc = exp_req_pc + 32'd4;
                fire_count++;
                if (first_fire < 0) first_fire = cyc;
            end
            if (redirect_valid) begin
                epoch++;
                mq.delete();
                if (redirect_pc[1:0] == 2'b00) begin
                    exp_req_pc = redirect_pc;
                    err_m      = 1'b0;
                end else begin
                    err_m = 1'b1;
                end
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            cyc++;
        end
    end

    // Observer for the wrap-around DUT.
    always @(negedge clk) begin
        if (!rst1_n) begin
            pend1 = 1'b0;
        end else begin
            if (instr_valid1 && instr_ready1) begin
                chk("t6_instr_word", instr1, word(instr_pc1));
                seen1.push_back(instr_pc1);
            end
            pend1      = imem_req_valid1 && imem_req_ready1;
            pend1_addr = imem_req_addr1;
        end
    end

    // Memories: drive responses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(memq[0].pc);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        imem_rsp_valid1 = rst1_n && pend1;
        imem_rsp_data1  = word(pend1_addr);
    end

    int pre3, pre5, f0;

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0;
        imem_req_ready = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_req_ready1 = 1'b1; instr_ready1 = 1'b1;
        redirect_valid1 = 1'b0; redirect_pc1 = 32'h0;
        imem_rsp_valid1 = 1'b0; imem_rsp_data1 = 32'h0;
        pend1 = 1'b0; pend1_addr = 32'h0;
        lat = 1; fire_count = 0; first_fire = -1; first_valid = -1;

        cycles(3);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_err", 32'(misaligned_err), 32'd0);
        chk("rst1_req_addr", imem_req_addr1, 32'hFFFF_FFF8);

        // 1: straight-line fetch, 1-cycle memory
        rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        cycles(20);
        chk("t1_latency", 32'(first_valid - first_fire), 32'd2);

        // 2: decoder stall; credits must stop issue without dropping anything
        instr_ready = 1'b0;
        cycles(5);
        f0 = fire_count;
        cycles(5);
        chk("t2_no_issue_full", 32'(fire_count - f0), 32'd0);
        chk("t2_valid_held", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        cycles(10);
        imem_req_ready = 1'b0;
        cycles(6);
        pre3 = seen.size();
        check_run("t12_order", 0, 32'h0, 10);

        // 3: redirect with two requests in flight on a slow memory
        lat = 3; imem_req_ready = 1'b1;
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        #1;
        chk("t3_no_issue_redirect", 32'(imem_req_valid), 32'd0);
        chk("t3_in_flight", 32'(memq.size()), 32'd2);
        cycles(1);
        redirect_valid = 1'b0; lat = 1;
        cycles(12);

        // 4: memory back-pressure
        imem_req_ready = 1'b0;
        cycles(5);
        chk("t4_req_held", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        cycles(10);
        check_run("t34_order", pre3, 32'h0000_0100, 8);

        // 5: misaligned redirect halts fetch until an aligned one
        pre5 = seen.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycles(1);
        redirect_valid = 1'b0;
        cycles(6);
        chk("t5_err_set", 32'(misaligned_err), 32'd1);
        chk("t5_no_req", 32'(imem_req_valid), 32'd0);
        chk("t5_nothing_out", 32'(seen.size()), 32'(pre5));
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycles(1);
        redirect_valid = 1'b0;
        cycles(12);
        chk("t5_err_clear", 32'(misaligned_err), 32'd0);
        check_run("t5_order", pre5, 32'h0000_0200, 4);

        // 6: PC wrap and mid-stream reset on the second DUT
        rst1_n = 1'b1;
        cycles(10);
        chk("t6_len", 32'(seen1.size() >= 3), 32'd1);
        if (seen1.size() >= 3) begin
            chk("t6_pc0", seen1[0], 32'hFFFF_FFF8);
            chk("t6_pc1", seen1[1], 32'hFFFF_FFFC);
            chk("t6_pc2", seen1[2], 32'h0000_0000);
        end
        rst1_n = 1'b0;
        #1;
        chk("t6_rst_req_valid", 32'(imem_req_valid1), 32'd0);
        chk("t6_rst_req_addr", imem_req_addr1, 32'hFFFF_FFF8);
        chk("t6_rst_instr_valid", 32'(instr_valid1), 32'd0);
        chk("t6_rst_instr", instr1, 32'h0000_0013);
        chk("t6_rst_instr_pc", instr_pc1, 32'h0);
        chk("t6_rst_err", 32'(misaligned_err1), 32'd0);
        cycles(2);
        seen1.delete();
        rst1_n = 1'b1;
        cycles(6);
        chk("t6_restart_len", 32'(seen1.size() >= 2), 32'd1);
        if (seen1.size() >= 2) begin
            chk("t6_restart_pc0", seen1[0], 32'hFFFF_FFF8);
            chk("t6_restart_pc1", seen1[1], 32'hFFFF_FFFC);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
